fifo_modport: RTL and testbench
===============================

Name: fifo_modport

Overview:
- Single-clock synchronous FIFO with programmable occupancy flags.
- Buffers DATA_WIDTH-bit words between a producer (wr_enb/wr_data) and a consumer (rd_enb/rd_data).
- Exposes full, empty, almost_full, almost_empty and half_full status for flow control and scoreboard checking.
- Sits as a leaf storage block inside the data path.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- DEPTH, 16, number of entries; must be a power of two and at least 4.
- ADDR_WIDTH, $clog2(DEPTH), pointer width; derived, not overridden.
- AFULL_LVL, DEPTH-2, occupancy at or above which almost_full asserts.
- AEMPTY_LVL, 2, occupancy at or below which almost_empty asserts.

Ports:
- clk input 1: single clock; all state updates on its rising edge.
- rstn input 1: reset, asynchronous, active-low.
- wr_enb input 1: write request.
- wr_data input DATA_WIDTH: write word.
- rd_enb input 1: read request.
- rd_data output DATA_WIDTH: registered read word.
- full output 1: count == DEPTH.
- empty output 1: count == 0.
- almost_full output 1: count >= AFULL_LVL.
- almost_empty output 1: count <= AEMPTY_LVL; includes count 0.
- half_full output 1: count >= DEPTH/2.

Behaviour:
- Reset (rstn=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, rd_data=0. Outputs then read empty=1, almost_empty=1, full=0, almost_full=0, half_full=0.
- Reset mid-operation discards all contents immediately. Memory array contents are not cleared and need not be reset. Operation resumes on the first edge after rstn rises.
- Write accepted when wr_enb=1 and full=0: mem[wr_ptr] <= wr_data, then wr_ptr increments.
- Write with full=1 is dropped; no state changes.
- Read accepted when rd_enb=1 and empty=0: rd_data <= mem[rd_ptr], then rd_ptr increments. Read latency is one clock; the word is valid on rd_data after the accepting edge.
- Read with empty=1 is ignored; rd_data holds its previous value.
- rd_data holds its value whenever no read is accepted.
- Pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- count is ADDR_WIDTH+1 bits:
  - +1 on accepted write only.
  - -1 on accepted read only.
  - Unchanged on both or neither.
- Simultaneous wr_enb and rd_enb:
  - Empty: only the write is accepted. There is no fall-through; rd_data is unchanged and count becomes 1.
  - Full: both are accepted; count stays DEPTH and full stays 1.
  - Otherwise: both are accepted and count is unchanged.
- All flags decode combinationally from the registered count. They change only after a clock edge or reset, with no glitch path from wr_enb or rd_enb.
- Order is strictly first-in, first-out, with no data loss except writes dropped while full.

Decomposition:
- Shared package fifo_pkg: DATA_WIDTH and DEPTH defaults, plus a typedef for the data word.
- Optional sub-module fifo_mem: a simple dual-port register array with write on clk and registered read.
- Pointer, count and flag logic stays in fifo_modport.

Test Plan:
- Reset: pulse rstn low for 1 ns mid-cycle, with no clock edge, after writing 5 words. Expect empty=1, almost_empty=1, full=0, half_full=0 and rd_data=0 immediately, asynchronously.
- Fill and drain: write 0x01..0x10 (16 words), then read 16 times. Expect:
  - half_full asserts after the 8th write.
  - almost_full asserts after the 14th write.
  - full asserts after the 16th write.
  - rd_data sequence 0x01..0x10, each word one cycle after its read.
  - empty asserts after the 16th read.
- Overflow and underflow: write 0xAA when full. Expect the FIFO still holds 16 entries, and 0xAA never appears in the drain. Then read when empty. Expect rd_data to hold 0x10 and count to stay 0.
- Simultaneous access:
  - With 4 entries, assert wr_enb and rd_enb for 10 cycles: count stays 4, and data order is preserved across pointer wrap.
  - When empty, do a simultaneous write of 0x55 and read: count becomes 1, rd_data is unchanged, and the next read returns 0x55.
- almost_empty boundary: with 3 entries, read 1. Expect almost_empty to go 0→1 at count 2 and remain 1 through count 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and types for the fifo_modport storage block.
// Imported by the interface, the memory and the FIFO top.
package fifo_pkg;

   localparam int FIFO_DATA_WIDTH = 8;
   localparam int FIFO_DEPTH      = 16;

   typedef logic [FIFO_DATA_WIDTH-1:0] data_t;

   // True when n is a power of two and at least 4
   function automatic bit depth_ok(input int n);
      return (n >= 4) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_modport_if.sv
// Producer/consumer bundle for fifo_modport.
// master drives requests, slave (the FIFO) returns data and status.
interface fifo_modport_if
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH
);

   logic                  wr_enb;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_enb;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic                  half_full;

   modport master (
      output wr_enb,
      output wr_data,
      output rd_enb,
      input  rd_data,
      input  full,
      input  empty,
      input  almost_full,
      input  almost_empty,
      input  half_full
   );

   modport slave (
      input  wr_enb,
      input  wr_data,
      input  rd_enb,
      output rd_data,
      output full,
      output empty,
      output almost_full,
      output almost_empty,
      output half_full
   );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port register array: write on clk, registered read.
// Array is not reset; only the read register is.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int DEPTH      = FIFO_DEPTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Storage write; contents survive reset by design
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read port, holds when no read is accepted
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/fifo_modport.sv
// Single-clock synchronous FIFO with occupancy flags.
// Pointers, count and flag decode live here; storage in fifo_mem.
module fifo_modport
   import fifo_pkg::*;
#(
   parameter  int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter  int DEPTH      = FIFO_DEPTH,
   localparam int ADDR_WIDTH = $clog2(DEPTH),
   parameter  int AFULL_LVL  = DEPTH - 2,
   parameter  int AEMPTY_LVL = 2
) (
   input logic           clk,
   input logic           rstn,
   fifo_modport_if.slave bus
);

   localparam int CW = ADDR_WIDTH + 1;

   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] HALF_C   = CW'(DEPTH / 2);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);

   localparam bit DEPTH_LEGAL = depth_ok(DEPTH);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [CW-1:0]         count;
   logic                  full_w;
   logic                  empty_w;
   logic                  wr_acc;
   logic                  rd_acc;
   logic [DATA_WIDTH-1:0] rd_q;

   // Flags decode only from the registered count
   assign full_w  = (count == DEPTH_C);
   assign empty_w = (count == '0);

   // A read frees a slot, so a full FIFO still takes a paired write
   assign rd_acc = bus.rd_enb & ~empty_w;
   assign wr_acc = bus.wr_enb & (~full_w | rd_acc);

   // Pointer and occupancy tracking
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (wr_acc & DEPTH_LEGAL),
      .wr_addr (wr_ptr),
      .wr_data (bus.wr_data),
      .rd_en   (rd_acc),
      .rd_addr (rd_ptr),
      .rd_data (rd_q)
   );

   assign bus.rd_data      = rd_q;
   assign bus.full         = full_w;
   assign bus.empty        = empty_w;
   assign bus.almost_full  = (count >= AFULL_C);
   assign bus.almost_empty = (count <= AEMPTY_C);
   assign bus.half_full    = (count >= HALF_C);

endmodule

// File: tb/tb_fifo_modport.sv
// Directed bench for fifo_modport with a queue-based reference.
// Expected words are queued on accepted writes and popped on reads.
module tb_fifo_modport;
   import fifo_pkg::*;

   logic clk;
   logic rstn;

   int checks   = 0;
   int failures = 0;

   data_t q[$];
   data_t exp_rd;

   fifo_modport_if #(.DATA_WIDTH(8)) bus ();

   fifo_modport dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_flags(input string tag);
      int n;
      n = q.size();
      chk({tag, ".full"},         bus.full,         n == 16);
      chk({tag, ".empty"},        bus.empty,        n == 0);
      chk({tag, ".almost_full"},  bus.almost_full,  n >= 14);
      chk({tag, ".almost_empty"}, bus.almost_empty, n <= 2);
      chk({tag, ".half_full"},    bus.half_full,    n >= 8);
   endtask

   // One clock of stimulus, then compare against the reference queue
   task automatic step(input string tag,
                       input logic we,
                       input data_t wd,
                       input logic re);
      bit rd_ok;
      bit wr_ok;
      rd_ok = re && (q.size() > 0);
      wr_ok = we && ((q.size() < 16) || rd_ok);
      bus.wr_enb  = we;
      bus.wr_data = wd;
      bus.rd_enb  = re;
      @(posedge clk);
      #1;
      if (rd_ok) exp_rd = q.pop_front();
      if (wr_ok) q.push_back(wd);
      bus.wr_enb = 1'b0;
      bus.rd_enb = 1'b0;
      chk({tag, ".rd_data"}, bus.rd_data, exp_rd);
      chk_flags(tag);
   endtask

   initial begin
      rstn        = 1'b0;
      bus.wr_enb  = 1'b0;
      bus.wr_data = '0;
      bus.rd_enb  = 1'b0;
      exp_rd      = '0;

      #3;
      chk("por.rd_data", bus.rd_data, 0);
      chk_flags("por");
      #9;
      rstn = 1'b1;

      // Async reset mid-cycle after a few writes and one read
      for (int i = 0; i < 5; i++) step("pre", 1'b1, data_t'(8'h31 + i), 1'b0);
      step("pre_rd", 1'b0, '0, 1'b1);
      chk("pre_rd.word", bus.rd_data, 8'h31);
      rstn = 1'b0;
      #1;
      q.delete();
      exp_rd = '0;
      chk("arst.rd_data", bus.rd_data, 0);
      chk("arst.empty", bus.empty, 1);
      chk("arst.almost_empty", bus.almost_empty, 1);
      chk("arst.full", bus.full, 0);
      chk("arst.half_full", bus.half_full, 0);
      rstn = 1'b1;

      // Fill with 0x01..0x10
      for (int i = 1; i <= 16; i++) begin
         step("fill", 1'b1, data_t'(i), 1'b0);
         if (i == 7)  chk("fill7.half_full", bus.half_full, 0);
         if (i == 8)  chk("fill8.half_full", bus.half_full, 1);
         if (i == 13) chk("fill13.almost_full", bus.almost_full, 0);
         if (i == 14) chk("fill14.almost_full", bus.almost_full, 1);
         if (i == 15) chk("fill15.full", bus.full, 0);
      end
      chk("fill16.full", bus.full, 1);

      // Overflow write is dropped
      step("ovf", 1'b1, 8'hAA, 1'b0);
      chk("ovf.full", bus.full, 1);

      // Drain: 0x01..0x10, never 0xAA
      for (int i = 1; i <= 16; i++) begin
         step("drain", 1'b0, '0, 1'b1);
         chk("drain.word", bus.rd_data, i);
      end
      chk("drain.empty", bus.empty, 1);

      // Underflow read holds rd_data
      step("udf", 1'b0, '0, 1'b1);
      chk("udf.hold", bus.rd_data, 8'h10);
      chk("udf.empty", bus.empty, 1);

      // almost_empty boundary from 3 entries down to 0
      for (int i = 0; i < 3; i++) step("ae_wr", 1'b1, data_t'(8'h41 + i), 1'b0);
      chk("ae3.almost_empty", bus.almost_empty, 0);
      step("ae_rd", 1'b0, '0, 1'b1);
      chk("ae2.almost_empty", bus.almost_empty, 1);
      step("ae_rd", 1'b0, '0, 1'b1);
      chk("ae1.almost_empty", bus.almost_empty, 1);
      step("ae_rd", 1'b0, '0, 1'b1);
      chk("ae0.almost_empty", bus.almost_empty, 1);
      chk("ae0.word", bus.rd_data, 8'h43);

      // Simultaneous access while empty: write only, no fall-through
      step("sim_e", 1'b1, 8'h55, 1'b1);
      chk("sim_e.hold", bus.rd_data, 8'h43);
      chk("sim_e.empty", bus.empty, 0);
      step("sim_e_rd", 1'b0, '0, 1'b1);
      chk("sim_e_rd.word", bus.rd_data, 8'h55);

      // Four entries, then 10 paired cycles across pointer wrap
      for (int i = 0; i < 4; i++) step("sim_wr", 1'b1, data_t'(8'h60 + i), 1'b0);
      for (int i = 0; i < 10; i++) begin
         step("sim", 1'b1, data_t'(8'h70 + i), 1'b1);
         chk("sim.count4", q.size() == 4 && !bus.empty && !bus.half_full, 1);
      end
      chk("sim.last", bus.rd_data, 8'h75);
      for (int i = 0; i < 4; i++) step("sim_dr", 1'b0, '0, 1'b1);
      chk("sim_dr.last", bus.rd_data, 8'h79);
      chk("sim_dr.empty", bus.empty, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
